// File: rtl/mul_sequencer.sv
// ============================================================================
// Module   : mul_sequencer
// Brief    : EX-stage sequencer for MUL (ALU code 4'b1010); radix-2 shift-add,
//            one multiplier bit per cycle, stalls the pipeline until done.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int         CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] C_MUL    = 4'b1010;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;

  logic             w_start;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0] w_mplier_step;

  // Reset is folded in so stall_o reads 0 while rst_n_i is held low.
  assign w_start = rst_n_i & (r_state == S_IDLE) & req_i & (ALUCtrl_i == C_MUL) & ~flush_i;

  always_comb begin
    w_acc_step    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_step = r_mplier >> 1;
    w_last        = (r_count == C_LAST) || (EARLY_TERM && (w_mplier_step == '0));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (flush_i)     w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if (w_start) begin
      r_acc    <= '0;
      r_mcand  <= data1_i;
      r_mplier <= data2_i;
      r_count  <= '0;
    end else if ((r_state == S_RUN) && !flush_i) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_step;
      r_count  <= r_count + 1'b1;
      if (w_last) r_result <= w_acc_step;
    end
  end

  assign stall_o  = w_start | (rst_n_i & (r_state == S_RUN) & ~flush_i);
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE) & ~flush_i;
  assign result_o = r_result;

endmodule

`default_nettype wire
